control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer_if.sv | 40 ++++
 rtl/control_sequencer.sv | 137 +++++++++++++
 tb/tb_control_sequencer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
// Handshake and strobe bundle between the instruction decoder/memories
// and the control sequencer.
interface control_sequencer_if;
    logic        start;
    logic        halt;
    logic        stall;
    logic [5:0]  ir_op;
    logic        sel_DM_rd;
    logic        sel_DM_wr;
    logic        sel_pc_load;
    logic        sel_LR_load;
    logic        sel_out_port;
    logic        pm_en;
    logic        ir_load;
    logic        en_dec;
    logic        alu_en;
    logic        rf_wr;
    logic        dm_rd;
    logic        dm_wr;
    logic        pc_inc;
    logic        pc_load;
    logic        lr_load;
    logic        out_port_en;
    logic        running;
    logic [15:0] instr_count;

    modport master (
        output start, halt, stall, ir_op,
        output sel_DM_rd, sel_DM_wr, sel_pc_load, sel_LR_load, sel_out_port,
        input  pm_en, ir_load, en_dec, alu_en, rf_wr, dm_rd, dm_wr,
        input  pc_inc, pc_load, lr_load, out_port_en, running, instr_count
    );

    modport slave (
        input  start, halt, stall, ir_op,
        input  sel_DM_rd, sel_DM_wr, sel_pc_load, sel_LR_load, sel_out_port,
        output pm_en, ir_load, en_dec, alu_en, rf_wr, dm_rd, dm_wr,
        output pc_inc, pc_load, lr_load, out_port_en, running, instr_count
    );
endinterface

// File: rtl/control_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB control
// strobes decoded from state, plus a retired-instruction counter.
module control_sequencer #(
    parameter int unsigned MEM_WAIT = 1
) (
    input logic               clk,
    input logic               rst,
    control_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, EXEC, MEM, WB
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT - 1);

    state_t      state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic [15:0] cnt_q, cnt_d;
    logic        retire;

    logic pm_en, ir_load, en_dec, alu_en, rf_wr;
    logic dm_rd, dm_wr, pc_inc, pc_load, lr_load, out_port_en;

    function automatic logic wr_class(input logic [5:0] op);
        logic w;
        case (op[5:2])
            4'b0000: w = op[1];
            4'b0001: w = (op[1:0] != 2'b01);
            4'b0010, 4'b0110, 4'b0111,
            4'b1000, 4'b1001, 4'b1110: w = 1'b1;
            4'b1011: w = ~op[1];
            default: w = 1'b0;
        endcase
        return w;
    endfunction

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        retire      = 1'b0;
        pm_en       = 1'b0;
        ir_load     = 1'b0;
        en_dec      = 1'b0;
        alu_en      = 1'b0;
        rf_wr       = 1'b0;
        dm_rd       = 1'b0;
        dm_wr       = 1'b0;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        lr_load     = 1'b0;
        out_port_en = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.halt)
                    state_d = FETCH;
            end
            FETCH: begin
                pm_en   = 1'b1;
                ir_load = 1'b1;
                if (!bus.stall)
                    state_d = DECODE;
            end
            DECODE: begin
                en_dec  = 1'b1;
                state_d = EXEC;
            end
            EXEC: begin
                alu_en      = 1'b1;
                out_port_en = bus.sel_out_port;
                wait_d      = 4'd0;
                if (bus.sel_DM_rd || bus.sel_DM_wr) begin
                    state_d = MEM;
                end else if (bus.sel_pc_load) begin
                    pc_load = 1'b1;
                    lr_load = bus.sel_LR_load;
                    retire  = 1'b1;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                dm_rd = bus.sel_DM_rd;
                dm_wr = bus.sel_DM_wr;
                // stall freezes the wait counter
                if (!bus.stall) begin
                    if (wait_q == WAIT_LAST) begin
                        if (bus.sel_DM_rd) begin
                            state_d = WB;
                        end else begin
                            pc_inc = 1'b1;
                            retire = 1'b1;
                        end
                    end else begin
                        wait_d = wait_q + 4'd1;
                    end
                end
            end
            WB: begin
                pc_inc = 1'b1;
                rf_wr  = wr_class(bus.ir_op);
                retire = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (retire)
            state_d = bus.halt ? IDLE : FETCH;
        cnt_d = retire ? cnt_q + 16'd1 : cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            wait_q  <= 4'd0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.pm_en       = pm_en;
    assign bus.ir_load     = ir_load;
    assign bus.en_dec      = en_dec;
    assign bus.alu_en      = alu_en;
    assign bus.rf_wr       = rf_wr;
    assign bus.dm_rd       = dm_rd;
    assign bus.dm_wr       = dm_wr;
    assign bus.pc_inc      = pc_inc;
    assign bus.pc_load     = pc_load;
    assign bus.lr_load     = lr_load;
    assign bus.out_port_en = out_port_en;
    assign bus.running     = (state_q != IDLE);
    assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: per-instruction strobe profiles
// are queued by the driver and checked by a monitor at each retirement.
module tb_control_sequencer;

    typedef struct {
        int          cyc;
        int          alu;
        int          rf;
        int          rd;
        int          wr;
        int          outp;
        int          inc;
        int          ld;
        int          lr;
        logic [15:0] cnt;
        logic        run;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    control_sequencer_if bus();

    control_sequencer #(.MEM_WAIT(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_count = 16'd0;
    exp_t        q[$];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input int cyc, input int alu, input int rf,
                                input int rd, input int wr, input int outp,
                                input int inc, input int ld, input int lr);
        exp_t e;
        e.cyc = cyc; e.alu = alu; e.rf = rf; e.rd = rd; e.wr = wr;
        e.outp = outp; e.inc = inc; e.ld = ld; e.lr = lr;
        e.cnt = 16'd0; e.run = 1'b0;
        return e;
    endfunction

    function automatic logic [10:0] strobes();
        return {bus.pm_en, bus.ir_load, bus.en_dec, bus.alu_en, bus.rf_wr,
                bus.dm_rd, bus.dm_wr, bus.pc_inc, bus.pc_load, bus.lr_load,
                bus.out_port_en};
    endfunction

    // monitor: accumulate strobe activity per instruction, compare at retire
    int   a_cyc, a_alu, a_rf, a_rd, a_wr, a_out, a_inc, a_ld, a_lr;
    bit   pend = 1'b0;
    exp_t cur;

    always @(negedge clk) begin
        if (rst) begin
            a_cyc = 0; a_alu = 0; a_rf = 0; a_rd = 0; a_wr = 0;
            a_out = 0; a_inc = 0; a_ld = 0; a_lr = 0;
            pend  = 1'b0;
        end else begin
            if (pend) begin
                check("instr_count", 32'(bus.instr_count), 32'(cur.cnt));
                check("running_after", 32'(bus.running), 32'(cur.run));
                pend = 1'b0;
            end
            if (bus.running) begin
                a_cyc++;
                a_alu += int'(bus.alu_en);
                a_rf  += int'(bus.rf_wr);
                a_rd  += int'(bus.dm_rd);
                a_wr  += int'(bus.dm_wr);
                a_out += int'(bus.out_port_en);
                a_inc += int'(bus.pc_inc);
                a_ld  += int'(bus.pc_load);
                a_lr  += int'(bus.lr_load);
                if (bus.pc_inc || bus.pc_load) begin
                    check("inc_load_excl", 32'(bus.pc_inc & bus.pc_load), 0);
                    if (q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_retire: got retire expected none");
                    end else begin
                        cur = q.pop_front();
                        check("cycles", a_cyc, cur.cyc);
                        check("alu_en", a_alu, cur.alu);
                        check("rf_wr", a_rf, cur.rf);
                        check("dm_rd", a_rd, cur.rd);
                        check("dm_wr", a_wr, cur.wr);
                        check("out_port_en", a_out, cur.outp);
                        check("pc_inc", a_inc, cur.inc);
                        check("pc_load", a_ld, cur.ld);
                        check("lr_load", a_lr, cur.lr);
                        pend = 1'b1;
                    end
                    a_cyc = 0; a_alu = 0; a_rf = 0; a_rd = 0; a_wr = 0;
                    a_out = 0; a_inc = 0; a_ld = 0; a_lr = 0;
                end
            end
        end
    end

    task automatic set_in(input logic [5:0] op, input logic [4:0] sel);
        bus.ir_op        = op;
        bus.sel_DM_rd    = sel[4];
        bus.sel_DM_wr    = sel[3];
        bus.sel_pc_load  = sel[2];
        bus.sel_LR_load  = sel[1];
        bus.sel_out_port = sel[0];
    endtask

    // sel = {rd, wr, pc_load, lr_load, out_port}
    task automatic issue(input string nm, input logic [5:0] op,
                         input logic [4:0] sel, input int stall_at,
                         input int halt_at, input bit keep_start,
                         input int n_instr, input exp_t e);
        int k;
        for (int i = 0; i < n_instr; i++) begin
            exp_count = exp_count + 16'd1;
            e.cnt = exp_count;
            e.run = (i < n_instr - 1);
            q.push_back(e);
        end
        @(posedge clk); #1;
        set_in(op, sel);
        bus.start = 1'b1;
        bus.halt  = 1'b0;
        bus.stall = 1'b0;
        @(posedge clk); #1;
        bus.start = keep_start;
        for (k = 0; k < 60; k++) begin
            bus.halt  = (k >= halt_at);
            bus.stall = (k == stall_at);
            @(posedge clk); #1;
            if (!bus.running) break;
        end
        if (k == 60) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout_%s: got running expected idle", nm);
        end
        bus.stall = 1'b0;
        bus.start = 1'b0;
        bus.halt  = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.halt  = 1'b0;
        bus.stall = 1'b0;
        set_in(6'd0, 5'd0);
        #3;
        check("rst_strobes", 32'(strobes()), 0);
        check("rst_running", 32'(bus.running), 0);
        check("rst_count", 32'(bus.instr_count), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel_strobes", 32'(strobes()), 0);
        repeat (2) @(negedge clk);
        check("idle_hold", 32'(bus.running), 0);

        issue("add", 6'b000010, 5'b00000, -1, 0, 1'b0, 1,
              mk(4, 1, 1, 0, 0, 0, 1, 0, 0));
        issue("add_chain", 6'b000010, 5'b00000, -1, 4, 1'b0, 2,
              mk(4, 1, 1, 0, 0, 0, 1, 0, 0));
        issue("add_fstall", 6'b000010, 5'b00000, 0, 0, 1'b0, 1,
              mk(5, 1, 1, 0, 0, 0, 1, 0, 0));
        issue("ld", 6'b100000, 5'b10000, 4, 0, 1'b0, 1,
              mk(8, 1, 1, 4, 0, 0, 1, 0, 0));
        issue("sts", 6'b100100, 5'b01000, -1, 0, 1'b0, 1,
              mk(6, 1, 0, 0, 3, 0, 1, 0, 0));
        issue("jmp", 6'b110000, 5'b00100, -1, 0, 1'b0, 1,
              mk(3, 1, 0, 0, 0, 0, 0, 1, 0));
        issue("call", 6'b110100, 5'b00110, -1, 0, 1'b1, 1,
              mk(3, 1, 0, 0, 0, 0, 0, 1, 1));
        issue("br_taken", 6'b111100, 5'b00100, -1, 0, 1'b0, 1,
              mk(3, 1, 0, 0, 0, 0, 0, 1, 0));
        issue("br_not", 6'b111100, 5'b00000, -1, 0, 1'b0, 1,
              mk(4, 1, 0, 0, 0, 0, 1, 0, 0));
        issue("cp", 6'b000101, 5'b00000, -1, 0, 1'b0, 1,
              mk(4, 1, 0, 0, 0, 0, 1, 0, 0));
        issue("out", 6'b101110, 5'b00001, -1, 0, 1'b0, 1,
              mk(4, 1, 0, 0, 0, 1, 1, 0, 0));
        issue("cpi", 6'b001100, 5'b00000, -1, 0, 1'b0, 1,
              mk(4, 1, 0, 0, 0, 0, 1, 0, 0));
        issue("in", 6'b101100, 5'b00000, -1, 0, 1'b0, 1,
              mk(4, 1, 1, 0, 0, 0, 1, 0, 0));
        issue("op0001_00", 6'b000100, 5'b00000, -1, 0, 1'b0, 1,
              mk(4, 1, 1, 0, 0, 0, 1, 0, 0));
        issue("op0001_11", 6'b000111, 5'b00000, -1, 0, 1'b0, 1,
              mk(4, 1, 1, 0, 0, 0, 1, 0, 0));
        issue("op0110", 6'b011000, 5'b00000, -1, 0, 1'b0, 1,
              mk(4, 1, 1, 0, 0, 0, 1, 0, 0));
        issue("op1010", 6'b101000, 5'b00000, -1, 0, 1'b0, 1,
              mk(4, 1, 0, 0, 0, 0, 1, 0, 0));
        issue("nop", 6'b000000, 5'b00000, -1, 0, 1'b0, 1,
              mk(4, 1, 0, 0, 0, 0, 1, 0, 0));

        // reset asserted mid-store must drop dm_wr without a clock edge
        @(posedge clk); #1;
        set_in(6'b100100, 5'b01000);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.halt  = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        check("mid_store_dm_wr", 32'(bus.dm_wr), 1);
        rst = 1'b1;
        #1;
        check("rst_dm_wr", 32'(bus.dm_wr), 0);
        check("rst_pc_inc", 32'(bus.pc_inc), 0);
        check("rst_running2", 32'(bus.running), 0);
        check("rst_count2", 32'(bus.instr_count), 0);
        @(negedge clk);
        @(posedge clk); #1;
        rst       = 1'b0;
        bus.halt  = 1'b0;
        exp_count = 16'd0;
        set_in(6'd0, 5'd0);
        @(negedge clk);

        // preset the counter to 0xFFFF instead of retiring 65535 NOPs
        force dut.cnt_q = 16'hFFFF;
        @(posedge clk); #1;
        release dut.cnt_q;
        @(negedge clk);
        check("preset_count", 32'(bus.instr_count), 32'h0000FFFF);
        exp_count = 16'hFFFF;
        issue("wrap", 6'b000000, 5'b00000, -1, 0, 1'b0, 1,
              mk(4, 1, 0, 0, 0, 0, 1, 0, 0));
        check("wrap_idle", 32'(bus.running), 0);

        repeat (2) @(negedge clk);
        check("queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
